// File: rtl/axil_test_regs.sv
// axil_test_regs: AXI4-Lite slave test device.
// Provides ID/VERSION constants, two byte-writable scratch registers, a
// 64-bit free-running cycle counter read through a LO/HI shadow pair, and
// counters of completed write and read transactions. Firmware can use it
// to prove that a bus path works from end to end.
module axil_test_regs #(
    parameter int          ADDR_WIDTH = 32,
    parameter logic [31:0] ID_VALUE   = 32'h4E54_5030,
    parameter logic [31:0] VERSION    = 32'h0001_0000
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic [2:0]            s_axi_awprot,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [31:0]           s_axi_wdata,
    input  logic [3:0]            s_axi_wstrb,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [2:0]            s_axi_arprot,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [31:0]           s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Word index = address bits [5:2]
    localparam logic [3:0] IDX_ID      = 4'h0;
    localparam logic [3:0] IDX_VERSION = 4'h1;
    localparam logic [3:0] IDX_SCR0    = 4'h2;
    localparam logic [3:0] IDX_SCR1    = 4'h3;
    localparam logic [3:0] IDX_CYC_LO  = 4'h4;
    localparam logic [3:0] IDX_CYC_HI  = 4'h5;
    localparam logic [3:0] IDX_WR_CNT  = 4'h6;
    localparam logic [3:0] IDX_RD_CNT  = 4'h7;
    localparam logic [3:0] IDX_CTRL    = 4'h8;

    // Write response for a given word index: RW regs accept, RO regs refuse,
    // everything above CTRL is not decoded.
    function automatic logic [1:0] wr_resp_of(input logic [3:0] idx);
        logic [1:0] resp;
        case (idx)
            IDX_SCR0, IDX_SCR1, IDX_CTRL:            resp = RESP_OKAY;
            IDX_ID, IDX_VERSION, IDX_CYC_LO,
            IDX_CYC_HI, IDX_WR_CNT, IDX_RD_CNT:      resp = RESP_SLVERR;
            default:                                 resp = RESP_DECERR;
        endcase
        return resp;
    endfunction

    logic        r_ready_en;
    logic        r_aw_held;
    logic [3:0]  r_aw_idx;
    logic        r_w_held;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic        r_bvalid;
    logic [1:0]  r_bresp;
    logic        r_rvalid;
    logic [31:0] r_rdata;
    logic [1:0]  r_rresp;
    logic        r_cnt_en;
    logic        r_clr_pend;
    logic [63:0] r_cyc;
    logic [31:0] r_hi_shadow;
    logic [31:0] r_wr_cnt;
    logic [31:0] r_rd_cnt;

    logic        w_aw_hs;
    logic        w_w_hs;
    logic        w_b_hs;
    logic        w_ar_hs;
    logic        w_r_hs;
    logic        w_do_wr;
    logic        w_wr_ok;
    logic [3:0]  w_wr_idx;
    logic [31:0] w_wr_data;
    logic [3:0]  w_wr_strb;
    logic [1:0]  w_wr_resp;
    logic [3:0]  w_rd_idx;
    logic [31:0] w_rd_data;
    logic [1:0]  w_rd_resp;
    logic [31:0] w_scratch0;
    logic [31:0] w_scratch1;
    logic        w_unused;

    // Protection bits and undecoded address bits carry no meaning here.
    assign w_unused = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr, s_axi_araddr};

    // Readies stay low until the first edge after reset has been released.
    assign s_axi_awready = r_ready_en & ~r_aw_held & ~r_bvalid;
    assign s_axi_wready  = r_ready_en & ~r_w_held & ~r_bvalid;
    assign s_axi_arready = r_ready_en & ~r_rvalid;
    assign s_axi_bvalid  = r_bvalid;
    assign s_axi_bresp   = r_bresp;
    assign s_axi_rvalid  = r_rvalid;
    assign s_axi_rdata   = r_rdata;
    assign s_axi_rresp   = r_rresp;

    assign w_aw_hs = s_axi_awvalid & s_axi_awready;
    assign w_w_hs  = s_axi_wvalid & s_axi_wready;
    assign w_b_hs  = r_bvalid & s_axi_bready;
    assign w_ar_hs = s_axi_arvalid & s_axi_arready;
    assign w_r_hs  = r_rvalid & s_axi_rready;

    // A write fires as soon as address and data are both available, whether
    // taken from the holding registers or from this cycle's handshake.
    assign w_wr_idx  = r_aw_held ? r_aw_idx : s_axi_awaddr[5:2];
    assign w_wr_data = r_w_held ? r_wdata : s_axi_wdata;
    assign w_wr_strb = r_w_held ? r_wstrb : s_axi_wstrb;
    assign w_do_wr   = (r_aw_held | w_aw_hs) & (r_w_held | w_w_hs);
    assign w_wr_resp = wr_resp_of(w_wr_idx);
    assign w_wr_ok   = w_do_wr & (w_wr_resp == RESP_OKAY);
    assign w_rd_idx  = s_axi_araddr[5:2];

    // Ready enable: first edge out of reset opens the channels.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_ready_en <= 1'b0;
        else       r_ready_en <= 1'b1;
    end

    // AW/W holding registers; each channel is captured independently.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_aw_held <= 1'b0;
            r_aw_idx  <= '0;
            r_w_held  <= 1'b0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
        end else begin
            if (w_aw_hs) r_aw_idx <= s_axi_awaddr[5:2];
            if (w_w_hs) begin
                r_wdata <= s_axi_wdata;
                r_wstrb <= s_axi_wstrb;
            end
            if (w_do_wr) begin
                r_aw_held <= 1'b0;
                r_w_held  <= 1'b0;
            end else begin
                if (w_aw_hs) r_aw_held <= 1'b1;
                if (w_w_hs)  r_w_held  <= 1'b1;
            end
        end
    end

    // Write response: raised when the write fires, held until accepted.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_bvalid <= 1'b0;
            r_bresp  <= RESP_OKAY;
        end else if (w_do_wr) begin
            r_bvalid <= 1'b1;
            r_bresp  <= w_wr_resp;
        end else if (w_b_hs) begin
            r_bvalid <= 1'b0;
        end
    end

    // Scratch registers, one byte lane per strobe bit.
    for (genvar gi = 0; gi < 4; gi++) begin : g_scratch_lane
        logic [7:0] r_lane0;
        logic [7:0] r_lane1;

        // Byte-lane update of both scratch words.
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                r_lane0 <= '0;
                r_lane1 <= '0;
            end else if (w_wr_ok && w_wr_strb[gi]) begin
                if (w_wr_idx == IDX_SCR0) r_lane0 <= w_wr_data[gi*8 +: 8];
                if (w_wr_idx == IDX_SCR1) r_lane1 <= w_wr_data[gi*8 +: 8];
            end
        end

        assign w_scratch0[gi*8 +: 8] = r_lane0;
        assign w_scratch1[gi*8 +: 8] = r_lane1;
    end

    // CTRL: cnt_en is a plain bit; clr becomes a one-cycle pulse that acts
    // on the edge after the write.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt_en   <= 1'b1;
            r_clr_pend <= 1'b0;
        end else begin
            r_clr_pend <= 1'b0;
            if (w_wr_ok && (w_wr_idx == IDX_CTRL) && w_wr_strb[0]) begin
                r_cnt_en   <= w_wr_data[0];
                r_clr_pend <= w_wr_data[1];
            end
        end
    end

    // Cycle counter, HI shadow and transaction counters; clear has priority.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cyc       <= '0;
            r_hi_shadow <= '0;
            r_wr_cnt    <= '0;
            r_rd_cnt    <= '0;
        end else if (r_clr_pend) begin
            r_cyc       <= '0;
            r_hi_shadow <= '0;
            r_wr_cnt    <= '0;
            r_rd_cnt    <= '0;
        end else begin
            if (r_cnt_en) r_cyc <= r_cyc + 64'd1;
            if (w_ar_hs && (w_rd_idx == IDX_CYC_LO)) r_hi_shadow <= r_cyc[63:32];
            if (w_b_hs) r_wr_cnt <= r_wr_cnt + 32'd1;
            if (w_r_hs) r_rd_cnt <= r_rd_cnt + 32'd1;
        end
    end

    // Read data mux over the current register values (pre-edge values).
    always_comb begin
        w_rd_data = 32'hDEAD_BEEF;
        w_rd_resp = RESP_DECERR;
        if (w_rd_idx <= IDX_CTRL) w_rd_resp = RESP_OKAY;
        case (w_rd_idx)
            IDX_ID:      w_rd_data = ID_VALUE;
            IDX_VERSION: w_rd_data = VERSION;
            IDX_SCR0:    w_rd_data = w_scratch0;
            IDX_SCR1:    w_rd_data = w_scratch1;
            IDX_CYC_LO:  w_rd_data = r_cyc[31:0];
            IDX_CYC_HI:  w_rd_data = r_hi_shadow;
            IDX_WR_CNT:  w_rd_data = r_wr_cnt;
            IDX_RD_CNT:  w_rd_data = r_rd_cnt;
            IDX_CTRL:    w_rd_data = {31'd0, r_cnt_en};
            default:     w_rd_data = 32'hDEAD_BEEF;
        endcase
    end

    // Read channel: register data on AR handshake, hold until accepted.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_rresp  <= RESP_OKAY;
        end else if (w_ar_hs) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_rd_data;
            r_rresp  <= w_rd_resp;
        end else if (w_r_hs) begin
            r_rvalid <= 1'b0;
        end
    end

endmodule
